// File: rtl/digital_tube.sv
// digital_tube
//   Bus-writable driver for an 8-digit multiplexed common-anode seven-segment
//   display. DATA holds eight hex nibbles (digit k = DATA[4k+3:4k]); CTRL holds
//   the enable, decimal-point mask and blank mask. A prescaler sets how long
//   each digit stays lit; digit_sel/seg are registered and active-low.
//
//   Optional feature macro: TUBE_BLINK_EN adds CTRL bit1 BLINK and a slow
//   blink phase that toggles every 256 full frames.
//
// Ports
//   CLK        system clock
//   RST        synchronous, active-high reset
//   WE         bus write strobe
//   BE[3:0]    byte enables, BE[i] covers WD[8i+7:8i]
//   innerADDR  word offset: 0 = DATA, 1 = CTRL, 2..7 reserved (read 0)
//   WD[31:0]   write data
//   RD[31:0]   combinational readback of the addressed register
//   digit_sel  active-low digit enables, bit k lights digit k
//   seg        active-low segments {dp,g,f,e,d,c,b,a}
module digital_tube #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [2:0]  innerADDR,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic [7:0]  digit_sel,
  output logic [7:0]  seg
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_TC = PW'(SCAN_DIV - 1);

  // Writable CTRL bits; everything else stays 0 so it reads back as 0.
`ifdef TUBE_BLINK_EN
  localparam logic [31:0] CTRL_MASK = 32'h00FF_FF03;
`else
  localparam logic [31:0] CTRL_MASK = 32'h00FF_FF01;
`endif

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_CTRL = 3'd1;

  logic [31:0]   data_q;
  logic [31:0]   ctrl_q;
  logic [PW-1:0] pre_q;
  logic [2:0]    idx_q;

  logic       ctrl_en;
  logic [7:0] dp_mask;
  logic [7:0] blank_mask;
  logic [3:0] nibble;
  logic       blink_off;

  assign ctrl_en    = ctrl_q[0];
  assign dp_mask    = ctrl_q[15:8];
  assign blank_mask = ctrl_q[23:16];
  assign nibble     = data_q[{idx_q, 2'b00} +: 4];

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      default: p = 7'h0E;
    endcase
    return p;
  endfunction

  // Register file
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else if (WE) begin
      for (int i = 0; i < 4; i++) begin
        if (BE[i]) begin
          if (innerADDR == ADDR_DATA)
            data_q[8*i +: 8] <= WD[8*i +: 8];
          else if (innerADDR == ADDR_CTRL)
            ctrl_q[8*i +: 8] <= WD[8*i +: 8] & CTRL_MASK[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    RD = '0;
    case (innerADDR)
      ADDR_DATA: RD = data_q;
      ADDR_CTRL: RD = ctrl_q;
      default:   RD = '0;
    endcase
  end

  // Scan prescaler and digit index. Both sit at 0 while disabled so that
  // enabling always starts a fresh full dwell on digit 0.
  always_ff @(posedge CLK) begin
    if (RST || !ctrl_en) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PRE_TC) begin
      pre_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

`ifdef TUBE_BLINK_EN
  // Counts 7->0 index wraps (full frames); the phase flips on every 256th.
  logic [7:0] frame_q;
  logic       phase_q;

  always_ff @(posedge CLK) begin
    if (RST || !ctrl_en) begin
      frame_q <= '0;
      phase_q <= 1'b0;
    end else if (pre_q == PRE_TC && idx_q == 3'd7) begin
      frame_q <= frame_q + 8'd1;
      if (frame_q == 8'hFF)
        phase_q <= ~phase_q;
    end
  end

  assign blink_off = ctrl_q[1] & phase_q;
`else
  assign blink_off = 1'b0;
`endif

  // Output register, built from the state as it stands before the edge.
  always_ff @(posedge CLK) begin
    if (RST || !ctrl_en) begin
      digit_sel <= 8'hFF;
      seg       <= 8'hFF;
    end else begin
      digit_sel <= ~(8'd1 << idx_q);
      if (blank_mask[idx_q] || blink_off)
        seg <= 8'hFF;
      else
        seg <= {~dp_mask[idx_q], hex7(nibble)};
    end
  end

endmodule

// File: tb/tb_digital_tube.sv
module tb_digital_tube;

  localparam int SD = 4;

`ifdef TUBE_BLINK_EN
  localparam logic [31:0] M_CTRL_MASK = 32'h00FF_FF03;
`else
  localparam logic [31:0] M_CTRL_MASK = 32'h00FF_FF01;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WE = 1'b0;
  logic [3:0]  BE = 4'h0;
  logic [2:0]  innerADDR = 3'd0;
  logic [31:0] WD = 32'h0;
  logic [31:0] RD;
  logic [7:0]  digit_sel;
  logic [7:0]  seg;

  int n_chk  = 0;
  int n_pass = 0;

  digital_tube #(.SCAN_DIV(SD)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .BE(BE), .innerADDR(innerADDR),
    .WD(WD), .RD(RD), .digit_sel(digit_sel), .seg(seg)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Spec decode table (active-low, dp off)
  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Behavioural model: m_cnt is the number of consecutive edges seen with EN=1
  // since the display was last enabled; the digit and blink phase follow from it.
  logic [31:0] m_data = 0;
  logic [31:0] m_ctrl = 0;
  int          m_cnt  = 0;

  initial begin
    logic        r, w;
    logic [2:0]  a;
    logic [3:0]  b;
    logic [31:0] d;
    logic [7:0]  e_sel, e_seg;
    int          idx;
    forever begin
      @(posedge CLK);
      r = RST; w = WE; a = innerADDR; b = BE; d = WD;
      e_sel = 8'hFF; e_seg = 8'hFF;
      if (!r && m_ctrl[0]) begin
        idx   = (m_cnt / SD) % 8;
        e_sel = ~(8'd1 << idx);
        if (!m_ctrl[16 + idx]) begin
          e_seg = hex_tab[(m_data >> (4 * idx)) & 32'hF];
          if (m_ctrl[8 + idx]) e_seg[7] = 1'b0;
        end
`ifdef TUBE_BLINK_EN
        if (m_ctrl[1] && ((m_cnt / (8 * SD * 256)) % 2 == 1)) e_seg = 8'hFF;
`endif
      end
      if (r) begin
        m_data = 0; m_ctrl = 0; m_cnt = 0;
      end else begin
        m_cnt = m_ctrl[0] ? m_cnt + 1 : 0;
        if (w) begin
          for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
              if (a == 3'd0) m_data[8*i +: 8] = d[8*i +: 8];
              else if (a == 3'd1) m_ctrl[8*i +: 8] = d[8*i +: 8] & M_CTRL_MASK[8*i +: 8];
            end
          end
        end
      end
      #1;
      chk("digit_sel", {24'h0, digit_sel}, {24'h0, e_sel});
      chk("seg", {24'h0, seg}, {24'h0, e_seg});
      chk("RD", RD, (innerADDR == 3'd0) ? m_data : (innerADDR == 3'd1) ? m_ctrl : 32'h0);
    end
  end

  task automatic wr(input logic [2:0] a, input logic [3:0] b, input logic [31:0] d);
    @(negedge CLK);
    WE = 1'b1; innerADDR = a; BE = b; WD = d;
    @(negedge CLK);
    WE = 1'b0;
  endtask

  task automatic wait_sel(input logic [7:0] t, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      if (digit_sel == t) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    // Reset
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_sel", {24'h0, digit_sel}, 32'hFF);
    chk("rst_seg", {24'h0, seg}, 32'hFF);
    innerADDR = 3'd0; #1; chk("rst_rd0", RD, 32'h0);
    innerADDR = 3'd1; #1; chk("rst_rd1", RD, 32'h0);
    RST = 1'b0;

    // Scan
    wr(3'd0, 4'hF, 32'h7654_3210);
    wr(3'd1, 4'hF, 32'h1);
    @(negedge CLK);
    chk("scan_d0_sel", {24'h0, digit_sel}, 32'hFE);
    chk("scan_d0_seg", {24'h0, seg}, 32'hC0);
    repeat (4) @(negedge CLK);
    chk("scan_d1_sel", {24'h0, digit_sel}, 32'hFD);
    chk("scan_d1_seg", {24'h0, seg}, 32'hF9);
    repeat (28) @(negedge CLK);
    chk("scan_frame_sel", {24'h0, digit_sel}, 32'hFE);

    // Byte enables
    wr(3'd0, 4'b0010, 32'hFFFF_FFFF);
    innerADDR = 3'd0; #1;
    chk("be_rd", RD, 32'h7654_FF10);
    wait_sel(8'hFB, ok);
    chk("be_wait", {31'h0, ok}, 32'h1);
    chk("be_d2_seg", {24'h0, seg}, 32'h8E);

    // DP / blank
    wr(3'd1, 4'hF, 32'h0002_0101);
    wait_sel(8'hFE, ok);
    chk("dp_wait", {31'h0, ok}, 32'h1);
    chk("dp_d0_seg", {24'h0, seg}, 32'h40);
    wait_sel(8'hFD, ok);
    chk("blank_wait", {31'h0, ok}, 32'h1);
    chk("blank_d1_seg", {24'h0, seg}, 32'hFF);

    // Disable / re-enable
    repeat (3) @(negedge CLK);
    wr(3'd1, 4'hF, 32'h0);
    @(negedge CLK);
    chk("dis_sel", {24'h0, digit_sel}, 32'hFF);
    chk("dis_seg", {24'h0, seg}, 32'hFF);
    wr(3'd1, 4'hF, 32'h1);
    @(negedge CLK);
    chk("reen_sel", {24'h0, digit_sel}, 32'hFE);

    // Reserved offset
    wr(3'd5, 4'hF, 32'hFFFF_FFFF);
    innerADDR = 3'd5; #1; chk("rsv_rd5", RD, 32'h0);
    innerADDR = 3'd0; #1; chk("rsv_data", RD, 32'h7654_FF10);
    innerADDR = 3'd1; #1; chk("rsv_ctrl", RD, 32'h1);

`ifdef TUBE_BLINK_EN
    wr(3'd1, 4'hF, 32'h0);
    wr(3'd1, 4'hF, 32'h3);
    repeat (8192) @(negedge CLK);
    chk("blink_pre_seg", {24'h0, seg}, 32'hF8);
    @(negedge CLK);
    chk("blink_off_seg", {24'h0, seg}, 32'hFF);
    chk("blink_off_sel", {24'h0, digit_sel}, 32'hFE);
    repeat (8191) @(negedge CLK);
    chk("blink_end_seg", {24'h0, seg}, 32'hFF);
    @(negedge CLK);
    chk("blink_relit_seg", {24'h0, seg}, 32'hC0);
`endif

    // Randomized traffic, checked every cycle by the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      @(negedge CLK);
      RST = ($urandom_range(0, 99) == 0);
      WE  = ($urandom_range(0, 3) == 0);
      r   = $urandom_range(0, 9);
      innerADDR = (r < 4) ? 3'd0 : (r < 8) ? 3'd1 : 3'($urandom_range(0, 7));
      BE  = 4'($urandom);
      WD  = $urandom;
      if (innerADDR == 3'd1 && $urandom_range(0, 3) != 0) WD[0] = 1'b1;
      if (innerADDR == 3'd1 && $urandom_range(0, 1) == 0) WD[23:16] = 8'h00;
    end
    @(negedge CLK);
    RST = 1'b0; WE = 1'b0;
    repeat (2) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
